stage3_hazard_ctrl: RTL and testbench
=====================================

Name: stage3_hazard_ctrl

Overview:
- Controller at the hazard-unit end of the three-stage (fetch / execute / mem) pipeline control interface.
- Consumes status and exception signals from fetch and mem; drives stall, flush, PC-enable, redirect, rollback and trap-vector insertion back to fetch, execute and mem.
- Sequences multi-cycle events (trap entry, xRET, ifence rollback, halt) with an FSM; ordinary stalls and redirects are decoded combinationally in the RUN state.

Parameters:
WORD_W, 32, width of PC and vector buses
CAUSE_W, 4, width of exception cause code

Ports:
CLK  in  1  clock
RST  in  1  asynchronous active-high reset
rs1_e, rs2_e  in  5 each  source registers of the instruction in execute
rd_m  in  5  destination register of the instruction in mem
reg_write, csr_read, dren, dwen  in  1 each  mem-stage instruction attributes
valid_e, valid_m  in  1 each  execute / mem slot holds a real instruction
i_mem_busy, d_mem_busy  in  1 each  instruction / data bus busy
jump, branch, mispredict  in  1 each  mem-stage control-flow resolution
ret, ifence, fence_stall, halt  in  1 each  mem-stage xRET, ifence, fence-in-progress, halt
fault_insn, mal_insn, illegal_insn, breakpoint, env_m, mal_l, fault_l, mal_s, fault_s  in  1 each  exception flags
pc_m  in  WORD_W  PC of the mem-stage instruction
trap_vec, epc_in  in  WORD_W  xTVEC target and xEPC return target from CSR file
pc_en, npc_sel  out  1 each  fetch PC update enable; select resolved target
if_ex_stall, ex_mem_stall, if_ex_flush, ex_mem_flush  out  1 each  pipeline register control
iren, suppress_iren, suppress_data, rollback  out  1 each  fetch read enable / suppress, kill mem access, refetch from pc_m+4
priv_pc  out  WORD_W  inserted PC
insert_priv_pc  out  1  fetch loads priv_pc this cycle
exc_valid  out  1  one-cycle pulse to CSR file on trap entry
exc_cause  out  CAUSE_W  cause code for exc_valid
epc_out  out  WORD_W  PC latched at trap entry
halted  out  1  sticky halt status

Behaviour:
- Reset (async, RST=1): state=RUN; iren=1; pc_en=0; every other output 0, including priv_pc, epc_out, exc_cause and halted.
- exc = valid_m & OR(exception flags). Event priority: halt > exc > ret > ifence > redirect > stalls. With valid_m=0 all mem-stage events are ignored.
- Cause encoding (priority high to low): fault_insn=1, mal_insn=0, illegal_insn=2, breakpoint=3, env_m=11, mal_l=4, mal_s=6, fault_l=5, fault_s=7.
- RUN, no event:
  - mem_stall = valid_m & (dren|dwen) & d_mem_busy.
  - if_ex_stall = i_mem_busy | mem_stall.
  - ex_mem_stall = mem_stall.
  - pc_en = !if_ex_stall.
- RUN, redirect (valid_m & (jump | branch&mispredict)):
  - npc_sel=1 and if_ex_flush=1.
  - If i_mem_busy: pc_en=0 and ex_mem_stall=1, holding the branch in mem until the bus is idle.
  - Otherwise pc_en=1 in the same cycle.
- RUN, exc:
  - Same cycle: suppress_data=1, if_ex_flush=1, ex_mem_flush=1, pc_en=0, exc_valid=1.
  - Register exc_cause and epc_out=pc_m.
  - Next state: TRAP_INSERT if !i_mem_busy, else TRAP_DRAIN.
- RUN, ret: same flushes as exc, with no exc_valid and no suppress_data. Latch target = epc_in. Next state as for exc.
- TRAP_DRAIN: pc_en=0, both flushes=1, suppress_iren=1. Leave for TRAP_INSERT when i_mem_busy=0.
- TRAP_INSERT (exactly 1 cycle):
  - insert_priv_pc=1, pc_en=1.
  - priv_pc = trap_vec (trap) or the latched epc_in (ret).
  - Next state RUN.
- RUN, ifence:
  - if_ex_flush=1, ex_mem_flush=1, rollback=1, suppress_iren=1, pc_en=0.
  - Next state FENCE_WAIT.
- FENCE_WAIT:
  - Hold rollback=1, suppress_iren=1, pc_en=0, flushes=1.
  - When fence_stall=0 & i_mem_busy=0: one exit cycle with pc_en=1 and rollback=1 (fetch loads pc_m+4), then RUN.
- RUN, halt: next state HALTED. HALTED is sticky until RST: halted=1, iren=0, pc_en=0, both stalls=1, no flushes; all further events ignored.
- Simultaneous exc and redirect: the redirect is dropped. A redirect arriving while the FSM is outside RUN is ignored, because the flushes kill it.
- RST asserted in any state returns to reset values on the next edge; no partial trap commits (exc_valid never seen after reset).

Test Plan:
- Load in mem with d_mem_busy=1 for 3 cycles -> if_ex_stall=ex_mem_stall=1 and pc_en=0 for 3 cycles; pc_en=1 on the 4th.
- Branch mispredict with i_mem_busy=1 for 2 cycles -> npc_sel=1 throughout; pc_en=0 and ex_mem_stall=1 for 2 cycles; pc_en=1 on cycle 3; if_ex_flush=1 on all 3.
- illegal_insn and mal_l together, pc_m=0x200, trap_vec=0x100, i_mem_busy=0 -> cycle 0: exc_valid=1, exc_cause=2, suppress_data=1; cycle 1: insert_priv_pc=1, priv_pc=0x100; epc_out=0x200.
- ifence with fence_stall high for 4 cycles -> rollback=1 for 5 consecutive cycles; pc_en=1 only on the last; FSM back in RUN.
- halt with valid_m=1, then jump and exc -> halted=1, iren=0, pc_en=0 forever; no exc_valid; reset clears halted.
- RST pulsed in TRAP_DRAIN -> all outputs at reset values; no insert_priv_pc after release.

Source files
------------

// File: rtl/stage3_hazard_ctrl.sv
// Hazard-unit controller for a fetch / execute / mem pipeline. It decodes stalls
// and redirects combinationally and sequences trap, xRET, ifence and halt with an FSM.
module stage3_hazard_ctrl #(
    parameter int WORD_W  = 32,
    parameter int CAUSE_W = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [4:0]         rs1_e,
    input  logic [4:0]         rs2_e,
    input  logic [4:0]         rd_m,
    input  logic               reg_write,
    input  logic               csr_read,
    input  logic               dren,
    input  logic               dwen,
    input  logic               valid_e,
    input  logic               valid_m,
    input  logic               i_mem_busy,
    input  logic               d_mem_busy,
    input  logic               jump,
    input  logic               branch,
    input  logic               mispredict,
    input  logic               ret,
    input  logic               ifence,
    input  logic               fence_stall,
    input  logic               halt,
    input  logic               fault_insn,
    input  logic               mal_insn,
    input  logic               illegal_insn,
    input  logic               breakpoint,
    input  logic               env_m,
    input  logic               mal_l,
    input  logic               fault_l,
    input  logic               mal_s,
    input  logic               fault_s,
    input  logic [WORD_W-1:0]  pc_m,
    input  logic [WORD_W-1:0]  trap_vec,
    input  logic [WORD_W-1:0]  epc_in,
    output logic               pc_en,
    output logic               npc_sel,
    output logic               if_ex_stall,
    output logic               ex_mem_stall,
    output logic               if_ex_flush,
    output logic               ex_mem_flush,
    output logic               iren,
    output logic               suppress_iren,
    output logic               suppress_data,
    output logic               rollback,
    output logic [WORD_W-1:0]  priv_pc,
    output logic               insert_priv_pc,
    output logic               exc_valid,
    output logic [CAUSE_W-1:0] exc_cause,
    output logic [WORD_W-1:0]  epc_out,
    output logic               halted
);

    typedef enum logic [2:0] {
        S_RUN,
        S_TRAP_DRAIN,
        S_TRAP_INSERT,
        S_FENCE_WAIT,
        S_HALTED
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [CAUSE_W-1:0]   r_exc_cause;
    logic [WORD_W-1:0]    r_epc;
    logic [WORD_W-1:0]    r_ret_target;
    logic                 r_is_trap;

    logic                 w_exc;
    logic                 w_ret;
    logic                 w_ifence;
    logic                 w_halt;
    logic                 w_redirect;
    logic                 w_mem_stall;
    logic [CAUSE_W-1:0]   w_cause;

    // Operand/writeback fields are part of the interface but need no forwarding checks here.
    logic w_unused;
    assign w_unused = &{1'b0, rs1_e, rs2_e, rd_m, reg_write, csr_read, valid_e};

    assign w_exc = valid_m & (fault_insn | mal_insn | illegal_insn | breakpoint | env_m |
                              mal_l | fault_l | mal_s | fault_s);
    assign w_ret       = valid_m & ret;
    assign w_ifence    = valid_m & ifence;
    assign w_halt      = valid_m & halt;
    assign w_redirect  = valid_m & (jump | (branch & mispredict));
    assign w_mem_stall = valid_m & (dren | dwen) & d_mem_busy;

    always_comb begin
        if      (fault_insn)   w_cause = CAUSE_W'(1);
        else if (mal_insn)     w_cause = CAUSE_W'(0);
        else if (illegal_insn) w_cause = CAUSE_W'(2);
        else if (breakpoint)   w_cause = CAUSE_W'(3);
        else if (env_m)        w_cause = CAUSE_W'(11);
        else if (mal_l)        w_cause = CAUSE_W'(4);
        else if (mal_s)        w_cause = CAUSE_W'(6);
        else if (fault_l)      w_cause = CAUSE_W'(5);
        else                   w_cause = CAUSE_W'(7);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state      <= S_RUN;
            r_exc_cause  <= '0;
            r_epc        <= '0;
            r_ret_target <= '0;
            r_is_trap    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_RUN && !w_halt) begin
                if (w_exc) begin
                    r_exc_cause <= w_cause;
                    r_epc       <= pc_m;
                    r_is_trap   <= 1'b1;
                end else if (w_ret) begin
                    r_ret_target <= epc_in;
                    r_is_trap    <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_RUN: begin
                if (w_halt)              w_next_state = S_HALTED;
                else if (w_exc || w_ret) w_next_state = i_mem_busy ? S_TRAP_DRAIN : S_TRAP_INSERT;
                else if (w_ifence)       w_next_state = S_FENCE_WAIT;
            end
            S_TRAP_DRAIN:  if (!i_mem_busy) w_next_state = S_TRAP_INSERT;
            S_TRAP_INSERT: w_next_state = S_RUN;
            S_FENCE_WAIT:  if (!fence_stall && !i_mem_busy) w_next_state = S_RUN;
            S_HALTED:      w_next_state = S_HALTED;
            default:       w_next_state = S_RUN;
        endcase
    end

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
        pc_en          = 1'b0;
        npc_sel        = 1'b0;
        if_ex_stall    = 1'b0;
        ex_mem_stall   = 1'b0;
        if_ex_flush    = 1'b0;
        ex_mem_flush   = 1'b0;
        iren           = 1'b1;
        suppress_iren  = 1'b0;
        suppress_data  = 1'b0;
        rollback       = 1'b0;
        priv_pc        = '0;
        insert_priv_pc = 1'b0;
        exc_valid      = 1'b0;
        exc_cause      = r_exc_cause;
        if (!RST) begin
            case (r_state)
                S_RUN: begin
                    if (w_halt) begin
                        if_ex_stall  = 1'b1;
                        ex_mem_stall = 1'b1;
                    end else if (w_exc) begin
                        suppress_data = 1'b1;
                        if_ex_flush   = 1'b1;
                        ex_mem_flush  = 1'b1;
                        exc_valid     = 1'b1;
                        exc_cause     = w_cause;
                    end else if (w_ret) begin
                        if_ex_flush  = 1'b1;
                        ex_mem_flush = 1'b1;
                    end else if (w_ifence) begin
                        if_ex_flush   = 1'b1;
                        ex_mem_flush  = 1'b1;
                        rollback      = 1'b1;
                        suppress_iren = 1'b1;
                    end else if (w_redirect) begin
                        // A busy fetch bus holds the branch in mem until the target can be issued.
                        npc_sel      = 1'b1;
                        if_ex_flush  = 1'b1;
                        ex_mem_stall = i_mem_busy;
                        pc_en        = !i_mem_busy;
                    end else begin
                        if_ex_stall  = i_mem_busy | w_mem_stall;
                        ex_mem_stall = w_mem_stall;
                        pc_en        = !(i_mem_busy | w_mem_stall);
                    end
                end
                S_TRAP_DRAIN: begin
                    if_ex_flush   = 1'b1;
                    ex_mem_flush  = 1'b1;
                    suppress_iren = 1'b1;
                end
                S_TRAP_INSERT: begin
                    insert_priv_pc = 1'b1;
                    pc_en          = 1'b1;
                    priv_pc        = r_is_trap ? trap_vec : r_ret_target;
                end
                S_FENCE_WAIT: begin
                    if_ex_flush  = 1'b1;
                    ex_mem_flush = 1'b1;
                    rollback     = 1'b1;
                    if (!fence_stall && !i_mem_busy) pc_en = 1'b1;
                    else                             suppress_iren = 1'b1;
                end
                S_HALTED: begin
                    iren         = 1'b0;
                    if_ex_stall  = 1'b1;
                    ex_mem_stall = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign epc_out = r_epc;
    assign halted  = (r_state == S_HALTED);

endmodule

// File: tb/tb_stage3_hazard_ctrl.sv
// Directed bench for stage3_hazard_ctrl: each step drives inputs after a rising
// edge and compares outputs against hand-computed values before the next edge.
module tb_stage3_hazard_ctrl;

    localparam int WORD_W  = 32;
    localparam int CAUSE_W = 4;

    logic               CLK = 1'b0;
    logic               RST;
    logic [4:0]         rs1_e, rs2_e, rd_m;
    logic               reg_write, csr_read, dren, dwen, valid_e, valid_m;
    logic               i_mem_busy, d_mem_busy, jump, branch, mispredict;
    logic               ret, ifence, fence_stall, halt;
    logic               fault_insn, mal_insn, illegal_insn, breakpoint, env_m;
    logic               mal_l, fault_l, mal_s, fault_s;
    logic [WORD_W-1:0]  pc_m, trap_vec, epc_in;
    logic               pc_en, npc_sel, if_ex_stall, ex_mem_stall, if_ex_flush, ex_mem_flush;
    logic               iren, suppress_iren, suppress_data, rollback;
    logic [WORD_W-1:0]  priv_pc;
    logic               insert_priv_pc, exc_valid;
    logic [CAUSE_W-1:0] exc_cause;
    logic [WORD_W-1:0]  epc_out;
    logic               halted;

    int n_pass  = 0;
    int n_total = 0;

    always #5 CLK = ~CLK;

    stage3_hazard_ctrl #(.WORD_W(WORD_W), .CAUSE_W(CAUSE_W)) dut (
        .CLK(CLK), .RST(RST), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_m(rd_m),
        .reg_write(reg_write), .csr_read(csr_read), .dren(dren), .dwen(dwen),
        .valid_e(valid_e), .valid_m(valid_m), .i_mem_busy(i_mem_busy), .d_mem_busy(d_mem_busy),
        .jump(jump), .branch(branch), .mispredict(mispredict), .ret(ret), .ifence(ifence),
        .fence_stall(fence_stall), .halt(halt), .fault_insn(fault_insn), .mal_insn(mal_insn),
        .illegal_insn(illegal_insn), .breakpoint(breakpoint), .env_m(env_m), .mal_l(mal_l),
        .fault_l(fault_l), .mal_s(mal_s), .fault_s(fault_s), .pc_m(pc_m), .trap_vec(trap_vec),
        .epc_in(epc_in), .pc_en(pc_en), .npc_sel(npc_sel), .if_ex_stall(if_ex_stall),
        .ex_mem_stall(ex_mem_stall), .if_ex_flush(if_ex_flush), .ex_mem_flush(ex_mem_flush),
        .iren(iren), .suppress_iren(suppress_iren), .suppress_data(suppress_data),
        .rollback(rollback), .priv_pc(priv_pc), .insert_priv_pc(insert_priv_pc),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .epc_out(epc_out), .halted(halted)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr();
        {rs1_e, rs2_e, rd_m} = '0;
        {reg_write, csr_read, dren, dwen, valid_e, valid_m} = '0;
        {i_mem_busy, d_mem_busy, jump, branch, mispredict} = '0;
        {ret, ifence, fence_stall, halt} = '0;
        {fault_insn, mal_insn, illegal_insn, breakpoint, env_m} = '0;
        {mal_l, fault_l, mal_s, fault_s} = '0;
        pc_m = '0; trap_vec = '0; epc_in = '0;
    endtask

    initial begin
        RST = 1'b1;
        clr();
        tick(); tick();
        check("rst_iren", iren, 1);
        check("rst_pc_en", pc_en, 0);
        check("rst_if_ex_stall", if_ex_stall, 0);
        check("rst_halted", halted, 0);
        check("rst_priv_pc", priv_pc, 0);
        check("rst_epc_out", epc_out, 0);
        check("rst_exc_cause", exc_cause, 0);
        check("rst_insert", insert_priv_pc, 0);
        RST = 1'b0;
        #1 check("idle_pc_en", pc_en, 1);

        // Load held in mem by a busy data bus.
        tick();
        valid_m = 1; dren = 1; d_mem_busy = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("ld_if_ex_stall", if_ex_stall, 1);
            check("ld_ex_mem_stall", ex_mem_stall, 1);
            check("ld_pc_en", pc_en, 0);
            tick();
        end
        d_mem_busy = 0;
        #1;
        check("ld_release_pc_en", pc_en, 1);
        check("ld_release_ex_mem_stall", ex_mem_stall, 0);
        tick(); clr();

        // Mispredict while the fetch bus is busy.
        valid_m = 1; branch = 1; mispredict = 1; i_mem_busy = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("br_npc_sel", npc_sel, 1);
            check("br_pc_en_busy", pc_en, 0);
            check("br_ex_mem_stall", ex_mem_stall, 1);
            check("br_flush", if_ex_flush, 1);
            tick();
        end
        i_mem_busy = 0;
        #1;
        check("br_npc_sel_last", npc_sel, 1);
        check("br_pc_en_last", pc_en, 1);
        check("br_flush_last", if_ex_flush, 1);
        check("br_ex_mem_stall_last", ex_mem_stall, 0);
        tick(); clr();
        valid_m = 1; branch = 1;
        #1 check("br_predicted_npc_sel", npc_sel, 0);
        tick(); clr();

        // Trap entry with two flags and a simultaneous jump that must be dropped.
        valid_m = 1; illegal_insn = 1; mal_l = 1; jump = 1; pc_m = 32'h200; trap_vec = 32'h100;
        #1;
        check("trap_exc_valid", exc_valid, 1);
        check("trap_exc_cause", exc_cause, 2);
        check("trap_suppress_data", suppress_data, 1);
        check("trap_pc_en", pc_en, 0);
        check("trap_npc_sel", npc_sel, 0);
        check("trap_ex_mem_flush", ex_mem_flush, 1);
        tick(); clr(); trap_vec = 32'h100;
        #1;
        check("trap_insert", insert_priv_pc, 1);
        check("trap_priv_pc", priv_pc, 32'h100);
        check("trap_insert_pc_en", pc_en, 1);
        check("trap_epc_out", epc_out, 32'h200);
        check("trap_exc_valid_once", exc_valid, 0);
        check("trap_cause_held", exc_cause, 2);
        tick();
        check("trap_back_run_insert", insert_priv_pc, 0);
        check("trap_back_run_pc_en", pc_en, 1);

        // Lower-priority cause pair: env_m outranks mal_s.
        valid_m = 1; env_m = 1; mal_s = 1;
        #1 check("env_cause", exc_cause, 11);
        tick(); clr(); tick();

        // xRET with a busy fetch bus: drain, then insert the latched epc_in.
        valid_m = 1; ret = 1; epc_in = 32'h444; i_mem_busy = 1; trap_vec = 32'h100;
        #1;
        check("ret_exc_valid", exc_valid, 0);
        check("ret_suppress_data", suppress_data, 0);
        check("ret_flush", if_ex_flush, 1);
        check("ret_pc_en", pc_en, 0);
        tick(); clr(); i_mem_busy = 1; trap_vec = 32'h100;
        #1;
        check("ret_drain_suppress_iren", suppress_iren, 1);
        check("ret_drain_insert", insert_priv_pc, 0);
        tick(); i_mem_busy = 0;
        #1 check("ret_drain_last_pc_en", pc_en, 0);
        tick();
        check("ret_insert", insert_priv_pc, 1);
        check("ret_priv_pc", priv_pc, 32'h444);
        tick();

        // ifence with fence_stall high for four cycles.
        valid_m = 1; ifence = 1; fence_stall = 1;
        #1;
        check("if_rollback_0", rollback, 1);
        check("if_pc_en_0", pc_en, 0);
        check("if_suppress_iren_0", suppress_iren, 1);
        tick(); clr(); fence_stall = 1;
        for (int i = 1; i < 4; i++) begin
            #1;
            check("if_rollback_wait", rollback, 1);
            check("if_pc_en_wait", pc_en, 0);
            tick();
        end
        fence_stall = 0;
        #1;
        check("if_rollback_exit", rollback, 1);
        check("if_pc_en_exit", pc_en, 1);
        tick();
        check("if_run_rollback", rollback, 0);
        check("if_run_pc_en", pc_en, 1);

        // Halt outranks a simultaneous exception and is sticky.
        valid_m = 1; halt = 1; illegal_insn = 1;
        #1;
        check("halt_exc_valid", exc_valid, 0);
        check("halt_pc_en", pc_en, 0);
        tick(); clr(); valid_m = 1; jump = 1; illegal_insn = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("halted", halted, 1);
            check("halted_iren", iren, 0);
            check("halted_pc_en", pc_en, 0);
            check("halted_exc_valid", exc_valid, 0);
            check("halted_flush", if_ex_flush, 0);
            check("halted_stall", if_ex_stall, 1);
            check("halted_npc_sel", npc_sel, 0);
            tick();
        end
        RST = 1;
        #1;
        check("halt_rst_halted", halted, 0);
        check("halt_rst_iren", iren, 1);
        tick(); RST = 0; clr();
        #1 check("halt_rst_pc_en", pc_en, 1);
        tick();

        // Reset pulse while draining a trap.
        valid_m = 1; fault_s = 1; pc_m = 32'h300; i_mem_busy = 1;
        #1 check("drain_cause", exc_cause, 7);
        tick(); clr(); i_mem_busy = 1;
        #1 check("drain_suppress_iren", suppress_iren, 1);
        RST = 1;
        #1;
        check("drain_rst_suppress_iren", suppress_iren, 0);
        check("drain_rst_pc_en", pc_en, 0);
        check("drain_rst_iren", iren, 1);
        check("drain_rst_flush", if_ex_flush, 0);
        check("drain_rst_epc_out", epc_out, 0);
        check("drain_rst_exc_cause", exc_cause, 0);
        tick(); RST = 0; i_mem_busy = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("drain_post_insert", insert_priv_pc, 0);
            check("drain_post_pc_en", pc_en, 1);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
